// File: rtl/contador_bcd_2dig.sv
// contador_bcd_2dig: two-digit BCD up/down counter with start/stop FSM and prescaler
// Ports: clk, rst (async, active-high); start/stop/clr/up controls;
//   bcd_unid/bcd_dez digits to the 7-segment decoders; tick, wrap, running status.
// Optional macro BLANK_ZERO_EN: bcd_dez shows 4'hF (blank) while the tens digit is 0.
module contador_bcd_2dig #(
  parameter int DIV   = 50_000_000,
  parameter int DIV_W = 26,
  parameter int MOD   = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  input  logic       up,
  output logic [3:0] bcd_unid,
  output logic [3:0] bcd_dez,
  output logic       tick,
  output logic       wrap,
  output logic       running
);
`ifdef BLANK_ZERO_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [3:0] UMAX = 4'((MOD - 1) % 10);
  localparam logic [3:0] TMAX = 4'((MOD - 1) / 10);
  localparam logic [DIV_W-1:0] PMAX = DIV_W'(DIV - 1);
  typedef enum logic {PARADO, CONTANDO} state_t;
  state_t state, state_n;
  logic [DIV_W-1:0] pre, pre_n;
  logic [3:0] dez, unid_n, dez_n;
  logic step, top, bottom, wrap_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= PARADO;
    else state <= state_n;
  // stop dominates start in both states
  always_comb
    state_n = (state == PARADO) ? ((start && !stop) ? CONTANDO : PARADO)
                                : (stop ? PARADO : CONTANDO);
  always_comb begin
    running = (state == CONTANDO);
    tick = running && (pre == PMAX);
  end
  // clr suppresses the step; the prescaler restarts on clr, tick, or leaving CONTANDO
  always_comb begin
    step = tick && !clr;
    top = (bcd_unid == UMAX) && (dez == TMAX);
    bottom = (bcd_unid == 4'd0) && (dez == 4'd0);
    pre_n = (running && state_n == CONTANDO && !clr && !tick) ? pre + 1'b1 : '0;
    wrap_n = step && (up ? top : bottom);
    unid_n = clr ? 4'd0 : !step ? bcd_unid
           : up ? ((top || bcd_unid == 4'd9) ? 4'd0 : bcd_unid + 4'd1)
           : (bottom ? UMAX : (bcd_unid == 4'd0) ? 4'd9 : bcd_unid - 4'd1);
    dez_n = clr ? 4'd0 : !step ? dez
          : up ? (top ? 4'd0 : (bcd_unid == 4'd9) ? dez + 4'd1 : dez)
          : (bottom ? TMAX : (bcd_unid == 4'd0) ? dez - 4'd1 : dez);
  end
  // bcd_dez is registered from the next tens value so the blanking mux never glitches
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre <= '0;
      bcd_unid <= 4'd0;
      dez <= 4'd0;
      bcd_dez <= BLANK ? 4'hF : 4'h0;
      wrap <= 1'b0;
    end else begin
      pre <= pre_n;
      bcd_unid <= unid_n;
      dez <= dez_n;
      bcd_dez <= (BLANK && dez_n == 4'd0) ? 4'hF : dez_n;
      wrap <= wrap_n;
    end
endmodule

// File: tb/tb_contador_bcd_2dig.sv
// tb_contador_bcd_2dig: directed bench with a value-level model checked every cycle
module tb_contador_bcd_2dig;
  localparam int DIV = 4;
  localparam int MOD = 60;
`ifdef BLANK_ZERO_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam int DZ0 = BLANK ? 15 : 0;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, clr = 1'b0, up = 1'b1;
  logic [3:0] bcd_unid, bcd_dez;
  logic tick, wrap, running;
  int tests = 0, failed = 0;
  bit chk_en = 1'b0;
  bit m_run = 1'b0, m_wrap = 1'b0;
  int m_pre = 0, m_v = 0;
  wire m_tick = m_run && (m_pre == DIV - 1);
  contador_bcd_2dig #(.DIV(DIV), .DIV_W(3), .MOD(MOD)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .up(up),
    .bcd_unid(bcd_unid), .bcd_dez(bcd_dez), .tick(tick), .wrap(wrap), .running(running)
  );
  always #5 clk = ~clk;
  function automatic int exp_dez(int v);
    return (BLANK && v < 10) ? 15 : v / 10;
  endfunction
  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // model works on the plain integer value 0..MOD-1
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_run <= 1'b0;
      m_pre <= 0;
      m_v <= 0;
      m_wrap <= 1'b0;
    end else begin
      m_run <= m_run ? !stop : (start && !stop);
      m_pre <= (m_run && !stop && !clr && !m_tick) ? m_pre + 1 : 0;
      m_v <= clr ? 0 : !m_tick ? m_v : up ? (m_v + 1) % MOD : (m_v + MOD - 1) % MOD;
      m_wrap <= !clr && m_tick && (up ? m_v == MOD - 1 : m_v == 0);
    end
  always @(negedge clk)
    if (chk_en) begin
      chk("unid", int'(bcd_unid), m_v % 10);
      chk("dez", int'(bcd_dez), exp_dez(m_v));
      chk("tick", int'(tick), int'(m_tick));
      chk("wrap", int'(wrap), int'(m_wrap));
      chk("running", int'(running), int'(m_run));
    end
  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (!tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tick) begin
      tests++;
      failed++;
      $display("FAIL tick_timeout: got no tick, expected one within 20 cycles at %0t", $time);
    end
  endtask
  task automatic adv(int n);
    repeat (n) begin
      wait_tick();
      @(posedge clk);
      #2;
    end
  endtask
  task automatic chk_val(string name, int u, int d);
    chk({name, "_unid"}, int'(bcd_unid), u);
    chk({name, "_dez"}, int'(bcd_dez), d);
  endtask
  initial begin
    #3 rst = 1'b1;
    chk_en = 1'b1;
    #1;
    chk_val("reset", 0, DZ0);
    chk("reset_running", int'(running), 0);
    chk("reset_wrap", int'(wrap), 0);
    chk("reset_tick", int'(tick), 0);
    #18 rst = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("idle_running", int'(running), 0);
    chk_val("idle", 0, DZ0);
    start = 1'b1;
    up = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    chk("start_running", int'(running), 1);
    repeat (44) @(posedge clk);
    #2;
    chk_val("run44", 1, 1);
    adv(48);
    chk_val("at59", 9, 5);
    adv(1);
    chk_val("wrap_up", 0, DZ0);
    chk("wrap_up_flag", int'(wrap), 1);
    @(posedge clk);
    #2;
    chk("wrap_up_one_cycle", int'(wrap), 0);
    up = 1'b0;
    adv(1);
    chk_val("wrap_down", 9, 5);
    chk("wrap_down_flag", int'(wrap), 1);
    adv(1);
    chk_val("down58", 8, 5);
    chk("down58_wrap", int'(wrap), 0);
    wait_tick();
    stop = 1'b1;
    @(posedge clk);
    #2 stop = 1'b0;
    chk_val("stop_step", 7, 5);
    chk("stop_running", int'(running), 0);
    repeat (20) @(posedge clk);
    #2;
    chk_val("stopped", 7, 5);
    start = 1'b1;
    stop = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("start_stop_conflict", int'(running), 0);
    start = 1'b0;
    stop = 1'b0;
    up = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    adv(40);
    chk_val("at37", 7, 3);
    wait_tick();
    clr = 1'b1;
    @(posedge clk);
    #2 clr = 1'b0;
    chk_val("clr_tick", 0, DZ0);
    chk("clr_tick_wrap", int'(wrap), 0);
    chk("clr_running", int'(running), 1);
    adv(3);
    #1 rst = 1'b1;
    #1;
    chk_val("rst_mid", 0, DZ0);
    chk("rst_mid_running", int'(running), 0);
    #3 rst = 1'b0;
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    adv(12);
    chk_val("restart12", 2, 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
